// File: rtl/sisc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sisc_pkg
// Description : Shared constants and types for the SISC instruction fetch
//               path: address width, reset PC and the fetch FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package sisc_pkg;

    localparam int          ADDR_W        = 16;
    localparam logic [15:0] RESET_PC      = 16'h0000;
    localparam logic [15:0] FETCH_CNT_MAX = 16'hFFFF;

    // IDLE  : one cycle after reset release, no request issued
    // REQ   : read request outstanding, waiting for mem_ack
    // HOLD  : ir holds an unconsumed instruction, waiting for fetch_en
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : pc_reg
// Description : Program counter register with parallel load, increment and
//               asynchronous reset to RESET_PC. Load has priority over
//               increment; increment wraps from all-ones to zero.
// Ports       : clk    - clock
//               rst_f  - asynchronous active-high reset
//               load_i - load d_i into the PC
//               inc_i  - increment the PC
//               d_i    - load value
//               q_o    - current PC
// Revision    : 1.0 - initial release
// ============================================================================
module pc_reg
    import sisc_pkg::*;
#(
    parameter int                ADDR_W   = sisc_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = sisc_pkg::RESET_PC[ADDR_W-1:0]
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              load_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] d_i,
    output logic [ADDR_W-1:0] q_o
);

    localparam logic [ADDR_W-1:0] c_one = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] pc_q;

    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            pc_q <= RESET_PC;
        end else if (load_i) begin
            pc_q <= d_i;
        end else if (inc_i) begin
            pc_q <= pc_q + c_one;
        end
    end

    assign q_o = pc_q;

endmodule
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_unit
// Description : Single-outstanding-request instruction fetch unit. Issues a
//               level read request at pc, captures the returned word into ir
//               on mem_ack, then holds it until the core consumes it with
//               fetch_en, at which point the PC advances (or branches) and
//               the next request is issued.
// Ports       : clk       - clock
//               rst_f     - asynchronous active-high reset
//               fetch_en  - consume current ir and advance
//               br_taken  - take br_addr as next PC (with fetch_en)
//               br_addr   - branch target
//               mem_rd    - read request (level)
//               mem_addr  - read word address
//               mem_data  - instruction word from memory
//               mem_ack   - one-cycle read completion pulse
//               ir        - registered instruction
//               ir_valid  - ir holds an unconsumed instruction
//               pc        - address of instruction in ir / being fetched
//               fetch_cnt - saturating count of completed fetches
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_unit
    import sisc_pkg::*;
#(
    parameter int                ADDR_W   = sisc_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = sisc_pkg::RESET_PC[ADDR_W-1:0]
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              fetch_en,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_addr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_data,
    input  logic              mem_ack,
    output logic [31:0]       ir,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       fetch_cnt
);

    fetch_state_t      state_q, state_d;
    logic [31:0]       ir_q, ir_d;
    logic              ir_valid_q, ir_valid_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              pc_load, pc_inc;
    logic [ADDR_W-1:0] pc_q;

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .rst_f  (rst_f),
        .load_i (pc_load),
        .inc_i  (pc_inc),
        .d_i    (br_addr),
        .q_o    (pc_q)
    );

    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            state_q    <= ST_IDLE;
            ir_q       <= 32'h0000_0000;
            ir_valid_q <= 1'b0;
            cnt_q      <= 16'h0000;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    // mem_ack is only honoured in REQ and fetch_en/br_taken only in HOLD;
    // in every other state they fall through to the hold-value defaults.
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        cnt_d      = cnt_q;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        mem_rd     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                mem_rd = 1'b1;
                if (mem_ack) begin
                    ir_d       = mem_data;
                    ir_valid_d = 1'b1;
                    if (cnt_q != FETCH_CNT_MAX) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (fetch_en) begin
                    if (br_taken) begin
                        pc_load = 1'b1;
                    end else begin
                        pc_inc = 1'b1;
                    end
                    ir_valid_d = 1'b0;
                    state_d    = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The request address is the PC itself, so it is stable for the whole
    // REQ state and reads RESET_PC while reset is asserted.
    assign mem_addr  = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign ir_valid  = ir_valid_q;
    assign fetch_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_unit
// Description : Directed self-checking bench for ifetch_unit. Instance dut
//               uses the default RESET_PC; instance dut2 uses 16'hFFFF to
//               exercise PC wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;

    logic        clk = 1'b0;
    int          checks = 0;
    int          failures = 0;

    // default instance
    logic        rst_f, fetch_en, br_taken, mem_ack;
    logic [15:0] br_addr;
    logic [31:0] mem_data;
    logic        mem_rd, ir_valid;
    logic [15:0] mem_addr, pc, fetch_cnt;
    logic [31:0] ir;

    // wrap instance
    logic        rst2, fetch_en2, br_taken2, mem_ack2;
    logic [15:0] br_addr2;
    logic [31:0] mem_data2;
    logic        mem_rd2, ir_valid2;
    logic [15:0] mem_addr2, pc2, fetch_cnt2;
    logic [31:0] ir2;

    always #5 clk = ~clk;

    ifetch_unit dut (
        .clk(clk), .rst_f(rst_f), .fetch_en(fetch_en), .br_taken(br_taken),
        .br_addr(br_addr), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_ack(mem_ack), .ir(ir), .ir_valid(ir_valid),
        .pc(pc), .fetch_cnt(fetch_cnt)
    );

    ifetch_unit #(.ADDR_W(16), .RESET_PC(16'hFFFF)) dut2 (
        .clk(clk), .rst_f(rst2), .fetch_en(fetch_en2), .br_taken(br_taken2),
        .br_addr(br_addr2), .mem_rd(mem_rd2), .mem_addr(mem_addr2),
        .mem_data(mem_data2), .mem_ack(mem_ack2), .ir(ir2), .ir_valid(ir_valid2),
        .pc(pc2), .fetch_cnt(fetch_cnt2)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_f = 1'b1;
        repeat (2) tick();
        checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL rst_mem_rd: got %0h expected 0", mem_rd); end
        checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL rst_mem_addr: got %h expected 0000", mem_addr); end
        checks++; if (pc !== 16'h0000) begin failures++; $display("FAIL rst_pc: got %h expected 0000", pc); end
        checks++; if (ir !== 32'h0) begin failures++; $display("FAIL rst_ir: got %h expected 00000000", ir); end
        checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL rst_ir_valid: got %0h expected 0", ir_valid); end
        checks++; if (fetch_cnt !== 16'h0) begin failures++; $display("FAIL rst_fetch_cnt: got %h expected 0000", fetch_cnt); end
        rst_f = 1'b0;
        #1;
        checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL idle_mem_rd: got %0h expected 0", mem_rd); end
        tick();
        checks++; if (mem_rd !== 1'b1) begin failures++; $display("FAIL req_mem_rd: got %0h expected 1", mem_rd); end
        checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL req_mem_addr: got %h expected 0000", mem_addr); end
    endtask

    task automatic test_first_fetch();
        mem_data = 32'h1012_0003;
        mem_ack  = 1'b1;
        tick();
        mem_ack  = 1'b0;
        checks++; if (ir !== 32'h1012_0003) begin failures++; $display("FAIL first_ir: got %h expected 10120003", ir); end
        checks++; if (ir_valid !== 1'b1) begin failures++; $display("FAIL first_ir_valid: got %0h expected 1", ir_valid); end
        checks++; if (fetch_cnt !== 16'd1) begin failures++; $display("FAIL first_fetch_cnt: got %0d expected 1", fetch_cnt); end
        checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL first_mem_rd_drop: got %0h expected 0", mem_rd); end
        checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL first_mem_addr: got %h expected 0000", mem_addr); end
        tick();
        checks++; if (ir_valid !== 1'b1 || ir !== 32'h1012_0003) begin failures++; $display("FAIL hold_stable: got ir=%h v=%0h expected ir=10120003 v=1", ir, ir_valid); end
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 3; i++) begin
            fetch_en = 1'b1;
            tick();
            fetch_en = 1'b0;
            checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL seq_valid_low[%0d]: got %0h expected 0", i, ir_valid); end
            checks++; if (mem_rd !== 1'b1) begin failures++; $display("FAIL seq_mem_rd[%0d]: got %0h expected 1", i, mem_rd); end
            checks++; if (mem_addr !== 16'(i)) begin failures++; $display("FAIL seq_mem_addr[%0d]: got %h expected %h", i, mem_addr, 16'(i)); end
            mem_data = 32'hA000_0000 + 32'(i);
            mem_ack  = 1'b1;
            tick();
            mem_ack  = 1'b0;
            checks++; if (ir_valid !== 1'b1) begin failures++; $display("FAIL seq_valid_high[%0d]: got %0h expected 1", i, ir_valid); end
            checks++; if (ir !== 32'hA000_0000 + 32'(i)) begin failures++; $display("FAIL seq_ir[%0d]: got %h expected %h", i, ir, 32'hA000_0000 + 32'(i)); end
            checks++; if (fetch_cnt !== 16'(i + 1)) begin failures++; $display("FAIL seq_fetch_cnt[%0d]: got %0d expected %0d", i, fetch_cnt, i + 1); end
        end
    endtask

    task automatic test_ignore();
        // stray ack while in HOLD
        mem_data = 32'hDEAD_BEEF;
        mem_ack  = 1'b1;
        tick();
        mem_ack  = 1'b0;
        checks++; if (ir !== 32'hA000_0003) begin failures++; $display("FAIL hold_ack_ir: got %h expected a0000003", ir); end
        checks++; if (fetch_cnt !== 16'd4) begin failures++; $display("FAIL hold_ack_cnt: got %0d expected 4", fetch_cnt); end
        checks++; if (mem_rd !== 1'b0 || ir_valid !== 1'b1) begin failures++; $display("FAIL hold_ack_state: got rd=%0h v=%0h expected rd=0 v=1", mem_rd, ir_valid); end
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        // fetch_en/branch while in REQ must be dropped
        fetch_en = 1'b1;
        br_taken = 1'b1;
        br_addr  = 16'h0099;
        tick();
        fetch_en = 1'b0;
        br_taken = 1'b0;
        checks++; if (mem_addr !== 16'h0004 || mem_rd !== 1'b1) begin failures++; $display("FAIL req_fetch_ignored: got addr=%h rd=%0h expected addr=0004 rd=1", mem_addr, mem_rd); end
        mem_data = 32'hB000_0004;
        mem_ack  = 1'b1;
        tick();
        mem_ack  = 1'b0;
        checks++; if (ir !== 32'hB000_0004 || pc !== 16'h0004) begin failures++; $display("FAIL req_after_ignore: got ir=%h pc=%h expected ir=b0000004 pc=0004", ir, pc); end
    endtask

    task automatic test_branch();
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        checks++; if (mem_addr !== 16'h0005) begin failures++; $display("FAIL br_pre_addr: got %h expected 0005", mem_addr); end
        mem_data = 32'hC000_0005;
        mem_ack  = 1'b1;
        tick();
        mem_ack  = 1'b0;
        fetch_en = 1'b1;
        br_taken = 1'b1;
        br_addr  = 16'h0040;
        tick();
        fetch_en = 1'b0;
        br_taken = 1'b0;
        br_addr  = 16'h1234;
        checks++; if (mem_addr !== 16'h0040 || mem_rd !== 1'b1) begin failures++; $display("FAIL br_target: got addr=%h rd=%0h expected addr=0040 rd=1", mem_addr, mem_rd); end
        mem_data = 32'hC000_0040;
        mem_ack  = 1'b1;
        tick();
        mem_ack  = 1'b0;
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        checks++; if (pc !== 16'h0041 || mem_addr !== 16'h0041) begin failures++; $display("FAIL br_after_plain: got pc=%h addr=%h expected 0041", pc, mem_addr); end
    endtask

    task automatic test_wait_states();
        mem_data = 32'h5555_5555;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if (mem_rd !== 1'b1 || mem_addr !== 16'h0041 || ir !== 32'hC000_0040 || ir_valid !== 1'b0) begin
                failures++;
                $display("FAIL wait[%0d]: got rd=%0h addr=%h ir=%h v=%0h expected rd=1 addr=0041 ir=c0000040 v=0",
                         i, mem_rd, mem_addr, ir, ir_valid);
            end
        end
        mem_data = 32'hD000_0041;
        mem_ack  = 1'b1;
        tick();
        mem_ack  = 1'b0;
        checks++; if (ir !== 32'hD000_0041 || ir_valid !== 1'b1) begin failures++; $display("FAIL wait_ack_ir: got ir=%h v=%0h expected ir=d0000041 v=1", ir, ir_valid); end
        checks++; if (fetch_cnt !== 16'd8) begin failures++; $display("FAIL wait_ack_cnt: got %0d expected 8", fetch_cnt); end
    endtask

    task automatic test_reset_mid_req();
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        checks++; if (mem_addr !== 16'h0042 || mem_rd !== 1'b1) begin failures++; $display("FAIL mid_pre: got addr=%h rd=%0h expected addr=0042 rd=1", mem_addr, mem_rd); end
        rst_f    = 1'b1;
        mem_data = 32'hE000_0042;
        mem_ack  = 1'b1;
        #1;
        checks++; if (ir !== 32'h0 || ir_valid !== 1'b0 || mem_rd !== 1'b0) begin failures++; $display("FAIL mid_async: got ir=%h v=%0h rd=%0h expected ir=0 v=0 rd=0", ir, ir_valid, mem_rd); end
        checks++; if (mem_addr !== 16'h0000 || fetch_cnt !== 16'h0) begin failures++; $display("FAIL mid_async_addr: got addr=%h cnt=%0d expected addr=0000 cnt=0", mem_addr, fetch_cnt); end
        tick();
        rst_f = 1'b0;
        tick();
        mem_ack = 1'b0;
        checks++; if (ir !== 32'h0 || ir_valid !== 1'b0 || fetch_cnt !== 16'h0) begin failures++; $display("FAIL mid_ack_dropped: got ir=%h v=%0h cnt=%0d expected 0", ir, ir_valid, fetch_cnt); end
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0000) begin failures++; $display("FAIL mid_restart: got rd=%0h addr=%h expected rd=1 addr=0000", mem_rd, mem_addr); end
        mem_data = 32'hF000_0000;
        mem_ack  = 1'b1;
        tick();
        mem_ack  = 1'b0;
        checks++; if (ir !== 32'hF000_0000 || fetch_cnt !== 16'd1) begin failures++; $display("FAIL mid_refetch: got ir=%h cnt=%0d expected ir=f0000000 cnt=1", ir, fetch_cnt); end
    endtask

    task automatic test_wrap();
        rst2 = 1'b0;
        tick();
        checks++; if (mem_addr2 !== 16'hFFFF || mem_rd2 !== 1'b1) begin failures++; $display("FAIL wrap_start: got addr=%h rd=%0h expected addr=ffff rd=1", mem_addr2, mem_rd2); end
        mem_data2 = 32'h1111_1111;
        mem_ack2  = 1'b1;
        tick();
        mem_ack2  = 1'b0;
        fetch_en2 = 1'b1;
        tick();
        fetch_en2 = 1'b0;
        checks++; if (mem_addr2 !== 16'h0000 || pc2 !== 16'h0000) begin failures++; $display("FAIL wrap_addr: got addr=%h pc=%h expected 0000", mem_addr2, pc2); end
        mem_data2 = 32'h2222_2222;
        mem_ack2  = 1'b1;
        tick();
        mem_ack2  = 1'b0;
        mem_data2 = 32'h3333_3333;
        mem_ack2  = 1'b1;
        tick();
        mem_ack2  = 1'b0;
        checks++; if (ir2 !== 32'h2222_2222 || ir_valid2 !== 1'b1) begin failures++; $display("FAIL wrap_stray_ack_ir: got ir=%h v=%0h expected ir=22222222 v=1", ir2, ir_valid2); end
        checks++; if (fetch_cnt2 !== 16'd2) begin failures++; $display("FAIL wrap_stray_ack_cnt: got %0d expected 2", fetch_cnt2); end
    endtask

    initial begin
        rst_f = 1'b1; fetch_en = 1'b0; br_taken = 1'b0; br_addr = 16'h0;
        mem_ack = 1'b0; mem_data = 32'h0;
        rst2 = 1'b1; fetch_en2 = 1'b0; br_taken2 = 1'b0; br_addr2 = 16'h0;
        mem_ack2 = 1'b0; mem_data2 = 32'h0;
        test_reset();
        test_first_fetch();
        test_sequential();
        test_ignore();
        test_branch();
        test_wait_states();
        test_reset_mid_req();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter ADDR_W, default 16, SHALL set the width of the program counter and memory address.
REQ-002 Parameter RESET_PC, default 16'h0000, SHALL set the PC value loaded on reset.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_f  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 fetch_en  input  1  SHALL be the core's "consume current IR, advance" strobe.
REQ-006 br_taken  input  1  SHALL select br_addr as next PC when sampled with fetch_en.
REQ-007 br_addr  input  ADDR_W  SHALL be the branch target.
REQ-008 mem_rd  output  1  SHALL be the level read request to instruction memory.
REQ-009 mem_addr  output  ADDR_W  SHALL be the read word address.
REQ-010 mem_data  input  32  SHALL be the instruction word, valid when mem_ack=1.
REQ-011 mem_ack  input  1  SHALL be a one-cycle pulse completing the outstanding read.
REQ-012 ir  output  32  SHALL be the registered instruction delivered to the core.
REQ-013 ir_valid  output  1  SHALL indicate ir holds an unconsumed instruction.
REQ-014 pc  output  ADDR_W  SHALL be the address of the instruction in ir or being fetched.
REQ-015 fetch_cnt  output  16  SHALL count completed fetches.

Function
REQ-016 FSM states SHALL be IDLE, REQ, HOLD.
REQ-017 IDLE: mem_rd=0; SHALL go to REQ on the first clock after reset release.
REQ-018 REQ: mem_rd=1, mem_addr=pc, both stable until mem_ack.
REQ-019 REQ with mem_ack=1: ir<=mem_data, ir_valid<=1, fetch_cnt+1, go to HOLD; mem_rd SHALL be 0 the next cycle.
REQ-020 mem_ack has no latency bound; REQ SHALL wait indefinitely.
REQ-021 HOLD: ir and ir_valid=1 SHALL stay stable until fetch_en=1.
REQ-022 HOLD with fetch_en=1: pc<=br_addr if br_taken, else pc+1 (wraps from all-ones to 0); ir_valid<=0; go to REQ.
REQ-023 Latency: fetch_en in cycle N -> mem_rd with new address in N+1; ack in N+1 -> ir_valid in N+2.
REQ-024 fetch_en and br_taken outside HOLD SHALL be ignored; no redirect is stored.
REQ-025 mem_ack outside REQ SHALL be ignored: no change to ir, ir_valid, or fetch_cnt.
REQ-026 fetch_cnt SHALL saturate at 16'hFFFF.
REQ-027 ir SHALL NOT change except on a REQ-state mem_ack or reset.

Reset
REQ-028 rst_f=1 SHALL immediately force state=IDLE, pc=RESET_PC, mem_addr=RESET_PC, mem_rd=0, ir=0, ir_valid=0, fetch_cnt=0.
REQ-029 Reset mid-REQ SHALL abandon the read; an ack arriving during or after reset SHALL be discarded.
REQ-030 rst_f and mem_ack in the same cycle: reset SHALL win.

Structure
REQ-031 ADDR_W, RESET_PC, and the FSM state encoding SHALL live in shared package sisc_pkg.
REQ-032 The PC register SHALL be sub-module pc_reg (load, increment, async reset to RESET_PC); all else SHALL stay in ifetch_unit.

Verification
REQ-033 Reset, then mem_ack with mem_data=32'h1012_0003 one cycle after mem_rd -> mem_addr=0, ir=32'h10120003, ir_valid=1, fetch_cnt=1.
REQ-034 Three fetch_en pulses, zero-wait acks -> mem_addr sequence 0,1,2,3; ir_valid low exactly one cycle after each fetch_en.
REQ-035 HOLD at pc=5, fetch_en=1 with br_taken=1 and br_addr=16'h0040 -> next mem_addr=16'h0040, then pc=16'h0041 after a plain fetch_en.
REQ-036 mem_ack delayed 7 cycles -> mem_rd and mem_addr held constant all 7 cycles; ir unchanged until the ack.
REQ-037 rst_f pulsed during REQ, ack in the same cycle -> ir=0, ir_valid=0, mem_rd=0; a fresh fetch starts at RESET_PC.
REQ-038 RESET_PC=16'hFFFF, one plain fetch_en -> next mem_addr=16'h0000; a stray mem_ack in HOLD leaves ir unchanged.
